hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  NB_REG  5  register-index width
  NB_CNT  16  stall-counter width
  DRAIN_CYCLES  4  cycles to drain the pipe after a halt instruction, range 1..15
REQ-002 Ports, one per line: name  direction  width  meaning. There is one clock; reset is asynchronous and active-low.
  clock  in  1  rising-edge clock
  reset  in  1  asynchronous active-low reset
  rs_dec, rt_dec  in  NB_REG  source registers of the decode-stage instruction
  uses_rs, uses_rt  in  1  decode instruction reads rs / rt
  is_branch_dec  in  1  conditional branch in decode
  branch_taken_dec  in  1  branch resolved taken in decode
  is_jump_dec  in  1  jump in decode
  is_halt_dec  in  1  HALT instruction in decode
  ex_write_reg  in  NB_REG  ID/EX destination
  ex_reg_write, ex_mem_read  in  1  ID/EX writes register / is load
  mem_write_reg  in  NB_REG  EX/MEM destination
  mem_reg_write, mem_mem_read  in  1  EX/MEM writes register / is load
  halt_req, step_req, resume_req  in  1  debug-unit single-cycle pulses
  pc_write  out  1  PC update enable
  if_id_write  out  1  IF/ID register enable
  if_id_flush  out  1  load NOP into IF/ID
  id_ex_bubble  out  1  load NOP into ID/EX
  pipe_enable  out  1  global enable for all pipeline registers
  program_done  out  1  sticky flag: program completed
  state  out  2  FSM state: RUN=0, DRAIN=1, HALT=2, STEP=3
  stall_cycles  out  NB_CNT  count of hazard-stall cycles

Function
REQ-003 match_ex = ex_reg_write and ex_write_reg != 0 and ((uses_rs and ex_write_reg == rs_dec) or (uses_rt and ex_write_reg == rt_dec)); match_mem is defined identically on the mem_* inputs.
REQ-004 hazard = (ex_mem_read and match_ex) or (is_branch_dec and match_ex) or (is_branch_dec and mem_mem_read and match_mem).
REQ-005 All control outputs are combinational from the current state and inputs, with zero-cycle latency; state, drain counter, program_done and stall_cycles are registered.
REQ-006 RUN or STEP with hazard=1: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0, pipe_enable=1; branch, jump and halt inputs are ignored.
REQ-007 RUN or STEP with hazard=0 and (branch_taken_dec or is_jump_dec): pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=0.
REQ-008 RUN or STEP with hazard=0 and is_halt_dec: pc_write=0, if_id_flush=1; the next state is DRAIN and the drain counter loads DRAIN_CYCLES.
REQ-009 RUN otherwise: pc_write=1, if_id_write=1, pipe_enable=1, if_id_flush=0, id_ex_bubble=0.
REQ-010 RUN next state: DRAIN per REQ-008, else HALT if halt_req, else RUN; is_halt_dec wins over a simultaneous halt_req.
REQ-011 DRAIN: pc_write=0, if_id_write=1, if_id_flush=1, pipe_enable=1, id_ex_bubble=0; the counter decrements each cycle; when counter==1 the next state is HALT and program_done is set.
REQ-012 DRAIN ignores halt_req, step_req and resume_req.
REQ-013 HALT: pipe_enable=0, pc_write=0, if_id_write=0, if_id_flush=0, id_ex_bubble=0.
REQ-014 HALT next state: RUN if resume_req and not program_done, else STEP if step_req and not program_done, else HALT; resume_req wins when both are pulsed.
REQ-015 STEP lasts exactly one cycle: outputs follow REQ-006..REQ-009; the next state is DRAIN per REQ-008, else HALT, including when the step stalled.
REQ-016 stall_cycles increments in each cycle where the REQ-006 condition holds, and saturates at all-ones.
REQ-017 program_done stays at 1 until reset; HALT with program_done=1 is terminal.

Reset
REQ-018 Reset asserted low asynchronously forces state=RUN, drain counter=0, program_done=0, stall_cycles=0.
REQ-019 During reset, outputs follow the RUN rules of REQ-006..REQ-009 for the current inputs.
REQ-020 Reset mid-DRAIN or mid-HALT abandons the operation with no residual state.
REQ-021 The first clock edge after reset release is a normal RUN cycle.

Verification
REQ-022 Load-use: ex_mem_read=1, ex_reg_write=1, ex_write_reg=8, rs_dec=8, uses_rs=1 -> pc_write=0, if_id_write=0, id_ex_bubble=1 in the same cycle; stall_cycles 0->1.
REQ-023 Register-0 exemption and branch stall: ex_write_reg=0 under the REQ-022 stimulus -> no stall; branch with rt_dec=9, mem_mem_read=1, mem_write_reg=9 -> stall; same branch with mem_mem_read=0 -> no stall.
REQ-024 Taken branch with hazard=0 -> if_id_flush=1, pc_write=1; with hazard=1 in the same cycle -> if_id_flush=0, stall per REQ-006.
REQ-025 HALT instruction in RUN with DRAIN_CYCLES=4 -> state 1 for exactly 4 cycles, then state 2 with program_done=1; subsequent resume_req and step_req are ignored.
REQ-026 Debug sequence halt_req -> step_req -> step_req -> resume_req -> states RUN, HALT, STEP, HALT, STEP, HALT, RUN; pipe_enable=1 only in RUN and STEP cycles.
REQ-027 Reset asserted in the second DRAIN cycle -> state=0, program_done=0, stall_cycles=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Pipeline hazard and run-control unit: detects load-use and branch-operand hazards,
// steers PC/IF/ID/ID/EX enables, and sequences RUN/DRAIN/HALT/STEP for the debug unit.
module hazard_control_unit #(
    parameter int NB_REG       = 5,
    parameter int NB_CNT       = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NB_REG-1:0] rs_dec,
    input  logic [NB_REG-1:0] rt_dec,
    input  logic              uses_rs,
    input  logic              uses_rt,
    input  logic              is_branch_dec,
    input  logic              branch_taken_dec,
    input  logic              is_jump_dec,
    input  logic              is_halt_dec,
    input  logic [NB_REG-1:0] ex_write_reg,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic [NB_REG-1:0] mem_write_reg,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic              halt_req,
    input  logic              step_req,
    input  logic              resume_req,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              pipe_enable,
    output logic              program_done,
    output logic [1:0]        state,
    output logic [NB_CNT-1:0] stall_cycles
);

    localparam int DRAIN_W = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2,
        ST_STEP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic                 done_q, done_d;
    logic [NB_CNT-1:0]    stall_cnt_q, stall_cnt_d;
    logic                 match_ex, match_mem, hazard;
    logic                 stall_now, go_drain;

    function automatic logic reg_match(
        input logic              wr_en,
        input logic [NB_REG-1:0] wr_reg,
        input logic              rd_rs,
        input logic [NB_REG-1:0] rs,
        input logic              rd_rt,
        input logic [NB_REG-1:0] rt
    );
        return wr_en && (wr_reg != '0) &&
               ((rd_rs && (wr_reg == rs)) || (rd_rt && (wr_reg == rt)));
    endfunction

    function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
        return (&v) ? v : v + {{(NB_CNT-1){1'b0}}, 1'b1};
    endfunction

    assign match_ex  = reg_match(ex_reg_write, ex_write_reg, uses_rs, rs_dec, uses_rt, rt_dec);
    assign match_mem = reg_match(mem_reg_write, mem_write_reg, uses_rs, rs_dec, uses_rt, rt_dec);
    assign hazard    = (ex_mem_read && match_ex) ||
                       (is_branch_dec && match_ex) ||
                       (is_branch_dec && mem_mem_read && match_mem);

    always_comb begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_enable  = 1'b0;
        stall_now    = 1'b0;
        go_drain     = 1'b0;
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        done_d       = done_q;

        case (state_q)
            ST_RUN, ST_STEP: begin
                pipe_enable = 1'b1;
                if (hazard) begin
                    // Hold PC and IF/ID, inject a bubble; control-flow inputs wait for the stall to clear.
                    id_ex_bubble = 1'b1;
                    stall_now    = 1'b1;
                end else if (branch_taken_dec || is_jump_dec) begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                    if_id_flush = 1'b1;
                end else if (is_halt_dec) begin
                    if_id_write = 1'b1;
                    if_id_flush = 1'b1;
                    go_drain    = 1'b1;
                end else begin
                    pc_write    = 1'b1;
                    if_id_write = 1'b1;
                end

                if (go_drain) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = DRAIN_W'(DRAIN_CYCLES);
                end else if (state_q == ST_STEP || halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_DRAIN: begin
                if_id_write = 1'b1;
                if_id_flush = 1'b1;
                pipe_enable = 1'b1;
                drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                if (drain_cnt_q <= DRAIN_W'(1)) begin
                    state_d = ST_HALT;
                    done_d  = 1'b1;
                end
            end
            default: begin
                // HALT after a completed program only leaves through reset.
                if (!done_q && resume_req) begin
                    state_d = ST_RUN;
                end else if (!done_q && step_req) begin
                    state_d = ST_STEP;
                end
            end
        endcase

        stall_cnt_d = stall_now ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign state        = state_q;
    assign program_done = done_q;
    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: a rule-level model is compared on every
// falling edge, and hand-computed literal expectations pin the key scenarios.
module tb_hazard_control_unit;

    localparam int NB_REG       = 5;
    localparam int NB_CNT       = 5;
    localparam int DRAIN_CYCLES = 4;
    localparam int SAT          = (1 << NB_CNT) - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic [NB_REG-1:0] rs_dec, rt_dec, ex_write_reg, mem_write_reg;
    logic              uses_rs, uses_rt, is_branch_dec, branch_taken_dec, is_jump_dec, is_halt_dec;
    logic              ex_reg_write, ex_mem_read, mem_reg_write, mem_mem_read;
    logic              halt_req, step_req, resume_req;
    logic              pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_enable, program_done;
    logic [1:0]        state;
    logic [NB_CNT-1:0] stall_cycles;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    hazard_control_unit #(
        .NB_REG(NB_REG), .NB_CNT(NB_CNT), .DRAIN_CYCLES(DRAIN_CYCLES)
    ) dut (
        .clock(clock), .reset(reset),
        .rs_dec(rs_dec), .rt_dec(rt_dec), .uses_rs(uses_rs), .uses_rt(uses_rt),
        .is_branch_dec(is_branch_dec), .branch_taken_dec(branch_taken_dec),
        .is_jump_dec(is_jump_dec), .is_halt_dec(is_halt_dec),
        .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_write_reg(mem_write_reg), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .halt_req(halt_req), .step_req(step_req), .resume_req(resume_req),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_enable(pipe_enable), .program_done(program_done),
        .state(state), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- rule-level model ----------------
    int m_mode;    // 0 RUN, 1 DRAIN, 2 HALT, 3 STEP
    int m_age;     // DRAIN cycles already completed
    bit m_done;
    int m_stalls;

    function automatic bit m_hazard();
        bit ex_hit, mem_hit;
        ex_hit  = ex_reg_write && (ex_write_reg != 0) &&
                  ((uses_rs && ex_write_reg == rs_dec) || (uses_rt && ex_write_reg == rt_dec));
        mem_hit = mem_reg_write && (mem_write_reg != 0) &&
                  ((uses_rs && mem_write_reg == rs_dec) || (uses_rt && mem_write_reg == rt_dec));
        return (ex_mem_read && ex_hit) || (is_branch_dec && ex_hit) ||
               (is_branch_dec && mem_mem_read && mem_hit);
    endfunction

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_enable}
    function automatic logic [4:0] m_ctl();
        if (m_mode == 1) return 5'b01101;
        if (m_mode == 2) return 5'b00000;
        if (m_hazard()) return 5'b00011;
        if (branch_taken_dec || is_jump_dec) return 5'b11101;
        if (is_halt_dec) return 5'b01101;
        return 5'b11001;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_mode <= 0; m_age <= 0; m_done <= 1'b0; m_stalls <= 0;
        end else begin
            case (m_mode)
                0, 3: begin
                    if (m_hazard()) m_stalls <= (m_stalls == SAT) ? SAT : m_stalls + 1;
                    if (!m_hazard() && !(branch_taken_dec || is_jump_dec) && is_halt_dec) begin
                        m_mode <= 1; m_age <= 0;
                    end else if (m_mode == 3 || halt_req) begin
                        m_mode <= 2;
                    end
                end
                1: begin
                    if (m_age == DRAIN_CYCLES - 1) begin m_mode <= 2; m_done <= 1'b1; end
                    else m_age <= m_age + 1;
                end
                default: begin
                    if (!m_done && resume_req) m_mode <= 0;
                    else if (!m_done && step_req) m_mode <= 3;
                end
            endcase
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("ctl", {27'd0, pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_enable}, {27'd0, m_ctl()});
            chk("state", {30'd0, state}, m_mode);
            chk("program_done", {31'd0, program_done}, {31'd0, m_done});
            chk("stall_cycles", {27'd0, stall_cycles}, m_stalls);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic clear_inputs();
        rs_dec = '0; rt_dec = '0; uses_rs = 0; uses_rt = 0;
        is_branch_dec = 0; branch_taken_dec = 0; is_jump_dec = 0; is_halt_dec = 0;
        ex_write_reg = '0; ex_reg_write = 0; ex_mem_read = 0;
        mem_write_reg = '0; mem_reg_write = 0; mem_mem_read = 0;
        halt_req = 0; step_req = 0; resume_req = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_use(input logic [NB_REG-1:0] dst, input logic [NB_REG-1:0] src);
        ex_mem_read = 1; ex_reg_write = 1; ex_write_reg = dst; rs_dec = src; uses_rs = 1;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        #1 reset = 1'b0;
        #2;
        chk("rst_state", {30'd0, state}, 0);
        chk("rst_done", {31'd0, program_done}, 0);
        chk("rst_stalls", {27'd0, stall_cycles}, 0);
        chk("rst_pc_write", {31'd0, pc_write}, 1);
        cmp_en = 1'b1;
        #9 reset = 1'b1;
        tick();
        chk("first_run_state", {30'd0, state}, 0);

        // load-use stall
        load_use(5'd8, 5'd8);
        #1;
        chk("lu_pc_write", {31'd0, pc_write}, 0);
        chk("lu_if_id_write", {31'd0, if_id_write}, 0);
        chk("lu_bubble", {31'd0, id_ex_bubble}, 1);
        chk("lu_stalls_before", {27'd0, stall_cycles}, 0);
        tick(); clear_inputs(); #1;
        chk("lu_stalls_after", {27'd0, stall_cycles}, 1);

        // register 0 never creates a dependency
        load_use(5'd0, 5'd0);
        #1;
        chk("r0_pc_write", {31'd0, pc_write}, 1);
        chk("r0_bubble", {31'd0, id_ex_bubble}, 0);
        tick(); clear_inputs();

        // branch operand produced by a load still in MEM
        is_branch_dec = 1; uses_rt = 1; rt_dec = 5'd9;
        mem_mem_read = 1; mem_reg_write = 1; mem_write_reg = 5'd9;
        #1 chk("br_mem_load_bubble", {31'd0, id_ex_bubble}, 1);
        tick();
        mem_mem_read = 0;
        #1 chk("br_mem_alu_bubble", {31'd0, id_ex_bubble}, 0);
        tick(); clear_inputs();

        // taken branch / jump without and with hazard
        is_branch_dec = 1; branch_taken_dec = 1;
        #1 chk("taken_flush", {31'd0, if_id_flush}, 1);
        chk("taken_pc_write", {31'd0, pc_write}, 1);
        tick();
        uses_rt = 1; rt_dec = 5'd9; ex_reg_write = 1; ex_write_reg = 5'd9;
        #1 chk("taken_hz_flush", {31'd0, if_id_flush}, 0);
        chk("taken_hz_pc_write", {31'd0, pc_write}, 0);
        chk("taken_hz_bubble", {31'd0, id_ex_bubble}, 1);
        tick(); clear_inputs();
        is_jump_dec = 1;
        #1 chk("jump_flush", {31'd0, if_id_flush}, 1);
        tick(); clear_inputs(); #1;
        chk("stalls_three", {27'd0, stall_cycles}, 3);

        // stall counter saturation
        load_use(5'd3, 5'd3);
        for (int i = 0; i < 40; i++) tick();
        clear_inputs(); #1;
        chk("stalls_saturated", {27'd0, stall_cycles}, SAT);

        // debug: halt, step, step, resume
        halt_req = 1;
        #1 chk("dbg_run_pe", {31'd0, pipe_enable}, 1);
        tick(); halt_req = 0; #1;
        chk("dbg_halt0", {30'd0, state}, 2);
        chk("dbg_halt0_pe", {31'd0, pipe_enable}, 0);
        step_req = 1; tick(); step_req = 0; #1;
        chk("dbg_step1", {30'd0, state}, 3);
        chk("dbg_step1_pe", {31'd0, pipe_enable}, 1);
        tick(); #1 chk("dbg_halt1", {30'd0, state}, 2);
        step_req = 1; tick(); step_req = 0;
        load_use(5'd4, 5'd4);
        #1 chk("dbg_step2_stall", {31'd0, id_ex_bubble}, 1);
        tick(); clear_inputs(); #1;
        chk("dbg_halt2", {30'd0, state}, 2);
        resume_req = 1; step_req = 1; tick(); clear_inputs(); #1;
        chk("dbg_resume", {30'd0, state}, 0);

        // HALT instruction (with simultaneous halt_req) drains then halts for good
        is_halt_dec = 1; halt_req = 1;
        #1 chk("hlt_pc_write", {31'd0, pc_write}, 0);
        chk("hlt_flush", {31'd0, if_id_flush}, 1);
        tick(); clear_inputs();
        for (int i = 0; i < DRAIN_CYCLES; i++) begin
            #1 chk("drain_state", {30'd0, state}, 1);
            chk("drain_done", {31'd0, program_done}, 0);
            if (i == 1) begin resume_req = 1; step_req = 1; halt_req = 1; end
            tick(); clear_inputs();
        end
        #1 chk("done_state", {30'd0, state}, 2);
        chk("done_flag", {31'd0, program_done}, 1);
        resume_req = 1; tick(); clear_inputs(); #1;
        chk("done_resume_ignored", {30'd0, state}, 2);
        step_req = 1; tick(); clear_inputs(); #1;
        chk("done_step_ignored", {30'd0, state}, 2);

        // reset in terminal HALT
        #1 reset = 1'b0;
        #1 chk("rst_halt_state", {30'd0, state}, 0);
        chk("rst_halt_done", {31'd0, program_done}, 0);
        #3 reset = 1'b1;

        // reset in the second DRAIN cycle
        tick(); load_use(5'd7, 5'd7);
        tick(); clear_inputs();
        is_halt_dec = 1;
        tick(); clear_inputs();
        tick(); #1;
        chk("drain2_state", {30'd0, state}, 1);
        chk("drain2_stalls", {27'd0, stall_cycles}, 1);
        #1 reset = 1'b0;
        #1 chk("rst_drain_state", {30'd0, state}, 0);
        chk("rst_drain_done", {31'd0, program_done}, 0);
        chk("rst_drain_stalls", {27'd0, stall_cycles}, 0);
        #3 reset = 1'b1;
        tick(); #1;
        chk("post_rst_state", {30'd0, state}, 0);
        chk("post_rst_pc_write", {31'd0, pc_write}, 1);
        tick();

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
